// File: rtl/fw_ctrl_unit.sv
// Forwarding and hazard control for a 5-stage pipeline: tracks EX/MEM destinations,
// selects the bypass source and requests load-use/split stalls. Optional counters: FW_PERF_CNT_EN.
package core;
    typedef enum logic [1:0] {NONE_STAGE = 2'd0, MEM_STAGE = 2'd1, WB_STAGE = 2'd2} fw_stage_t;
    typedef enum logic [1:0] {RS_NONE = 2'd0, RS1 = 2'd1, RS2 = 2'd2, RS_BOTH = 2'd3} fw_regs_t;
    typedef struct packed {
        fw_stage_t stage;
        fw_regs_t  regs;
    } fw_cntrl_bus_t;
    typedef struct packed {
        logic [31:0] rd;
    } bypass_bus_t;
endpackage

module fw_ctrl_unit (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_valid_i,
    input  logic [4:0]         id_rs1_i,
    input  logic [4:0]         id_rs2_i,
    input  logic               id_rs1_used_i,
    input  logic               id_rs2_used_i,
    input  logic [4:0]         id_rd_i,
    input  logic               id_rd_we_i,
    input  logic               id_is_load_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [31:0]        mem_result_i,
    input  logic [31:0]        wb_result_i,
    output logic               stall_o,
    output core::fw_cntrl_bus_t fw_cntrl_o,
    output core::bypass_bus_t  bypass_o,
    output logic [31:0]        perf_load_use_o,
    output logic [31:0]        perf_split_o
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } trk_t;

    localparam trk_t BUBBLE = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};
    localparam core::fw_cntrl_bus_t FW_NONE = '{stage: core::NONE_STAGE, regs: core::RS_NONE};

    trk_t                ex_q, mem_q;
    core::fw_cntrl_bus_t fw_q, fw_resolved;
    core::fw_stage_t     s1, s2;
    logic                load_use, split, hazard;

    // The younger instruction in EX takes priority over the one in MEM.
    function automatic core::fw_stage_t resolve(input logic used, input logic [4:0] rs,
                                                input trk_t ex, input trk_t mem);
        if (used && rs != 5'd0 && ex.valid && ex.rd == rs)
            return core::MEM_STAGE;
        else if (used && rs != 5'd0 && mem.valid && mem.rd == rs)
            return core::WB_STAGE;
        else
            return core::NONE_STAGE;
    endfunction

    always_comb begin
        s1          = resolve(id_valid_i & id_rs1_used_i, id_rs1_i, ex_q, mem_q);
        s2          = resolve(id_valid_i & id_rs2_used_i, id_rs2_i, ex_q, mem_q);
        load_use    = ex_q.is_load && (s1 == core::MEM_STAGE || s2 == core::MEM_STAGE);
        split       = (s1 != core::NONE_STAGE) && (s2 != core::NONE_STAGE) && (s1 != s2);
        hazard      = id_valid_i && !stall_i && !flush_i && (load_use || split);
        fw_resolved = FW_NONE;
        if (s1 != core::NONE_STAGE && s2 != core::NONE_STAGE)
            fw_resolved = '{stage: s1, regs: core::RS_BOTH};
        else if (s1 != core::NONE_STAGE)
            fw_resolved = '{stage: s1, regs: core::RS1};
        else if (s2 != core::NONE_STAGE)
            fw_resolved = '{stage: s2, regs: core::RS2};
    end

    assign stall_o = hazard;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            fw_q  <= FW_NONE;
        end else if (!stall_i) begin
            mem_q <= ex_q;
            if (hazard || flush_i) begin
                ex_q <= BUBBLE;
                fw_q <= FW_NONE;
            end else begin
                ex_q <= '{valid: id_valid_i & id_rd_we_i, rd: id_rd_i, is_load: id_is_load_i};
                fw_q <= fw_resolved;
            end
        end
    end

    assign fw_cntrl_o = fw_q;

    always_comb begin
        bypass_o.rd = '0;
        case (fw_q.stage)
            core::MEM_STAGE: bypass_o.rd = mem_result_i;
            core::WB_STAGE:  bypass_o.rd = wb_result_i;
            default:         bypass_o.rd = '0;
        endcase
    end

`ifdef FW_PERF_CNT_EN
    logic [31:0] lu_cnt_q, sp_cnt_q;

    // A cycle that is both load-use and split is attributed to load-use only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lu_cnt_q <= '0;
            sp_cnt_q <= '0;
        end else if (hazard) begin
            if (load_use) begin
                if (lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + 32'd1;
            end else if (sp_cnt_q != '1) begin
                sp_cnt_q <= sp_cnt_q + 32'd1;
            end
        end
    end

    assign perf_load_use_o = lu_cnt_q;
    assign perf_split_o    = sp_cnt_q;
`else
    assign perf_load_use_o = '0;
    assign perf_split_o    = '0;
`endif
endmodule

// File: tb/tb_fw_ctrl_unit.sv
// Directed scoreboard bench for fw_ctrl_unit: expected EX-stage forwarding is queued
// when an ID instruction is driven and compared one cycle later.
module tb_fw_ctrl_unit;
    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_we_i, id_is_load_i;
    logic [4:0]          id_rs1_i, id_rs2_i, id_rd_i;
    logic                stall_i, flush_i;
    logic [31:0]         mem_result_i, wb_result_i;
    logic                stall_o;
    core::fw_cntrl_bus_t fw_cntrl_o;
    core::bypass_bus_t   bypass_o;
    logic [31:0]         perf_load_use_o, perf_split_o;

`ifdef FW_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string           tag;
        core::fw_stage_t stage;
        core::fw_regs_t  regs;
        logic [31:0]     byp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    fw_ctrl_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .mem_result_i(mem_result_i), .wb_result_i(wb_result_i),
        .stall_o(stall_o), .fw_cntrl_o(fw_cntrl_o), .bypass_o(bypass_o),
        .perf_load_use_o(perf_load_use_o), .perf_split_o(perf_split_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = v;  id_rs1_i = r1; id_rs1_used_i = u1; id_rs2_i = r2; id_rs2_used_i = u2;
        id_rd_i = rd;    id_rd_we_i = we; id_is_load_i = ld;
    endtask

    task automatic pop_ex();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".stage"}, 32'(fw_cntrl_o.stage), 32'(e.stage));
            cmp({e.tag, ".regs"},  32'(fw_cntrl_o.regs),  32'(e.regs));
            cmp({e.tag, ".bypass"}, bypass_o.rd, e.byp);
        end
    endtask

    // ID inputs are already driven: check stall now, queue the EX result, then compare it.
    task automatic cycle(input string tag, input logic exp_stall, input core::fw_stage_t st,
                         input core::fw_regs_t rg, input logic [31:0] byp);
        #1;
        cmp({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
        sb.push_back('{tag, st, rg, byp});
        @(posedge clk_i);
        #1;
        pop_ex();
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        mem_result_i = 32'h11; wb_result_i = 32'h22;
        id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        cmp("rst.stall", 32'(stall_o), 32'd0);
        cmp("rst.stage", 32'(fw_cntrl_o.stage), 32'(core::NONE_STAGE));
        cmp("rst.regs", 32'(fw_cntrl_o.regs), 32'(core::RS_NONE));
        cmp("rst.bypass", bypass_o.rd, 32'd0);
        cmp("rst.lu", perf_load_use_o, 32'd0);
        cmp("rst.sp", perf_split_o, 32'd0);
        rst_i = 1'b0;

        // ADD x5 ; ADD x6,x5,x5
        id(1, 0, 1, 0, 1, 5, 1, 0);  cycle("add_x5", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 5, 1, 5, 1, 6, 1, 0);  cycle("add_x6", 0, core::MEM_STAGE, core::RS_BOTH, 32'h11);
        id(0, 5, 1, 5, 1, 0, 0, 0);  cycle("idle", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);

        // LW x7 ; ADD x8,x0,x7
        id(1, 0, 1, 0, 0, 7, 1, 1);  cycle("lw_x7", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 0, 1, 7, 1, 8, 1, 0);  cycle("lu_stall", 1, core::NONE_STAGE, core::RS_NONE, 32'd0);
        cycle("lu_fwd", 0, core::WB_STAGE, core::RS2, 32'h22);
        cmp("lu.count", perf_load_use_o, PERF ? 32'd1 : 32'd0);

        // ADD x1 ; ADD x2 ; SUB x3,x2,x1
        id(1, 0, 1, 0, 1, 1, 1, 0);  cycle("add_x1", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 0, 1, 0, 1, 2, 1, 0);  cycle("add_x2", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 2, 1, 1, 1, 3, 1, 0);  cycle("split_stall", 1, core::NONE_STAGE, core::RS_NONE, 32'd0);
        cycle("split_fwd", 0, core::WB_STAGE, core::RS1, 32'h22);
        cmp("split.count", perf_split_o, PERF ? 32'd1 : 32'd0);

        // LW x0 then read x0: never forwards, never stalls
        id(1, 0, 1, 0, 0, 0, 1, 1);  cycle("lw_x0", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 0, 1, 0, 1, 9, 1, 0);  cycle("read_x0", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);

        // LW x10,0(x9) forwards x9; ADD x11,x10 under external stall for 3 cycles
        id(1, 9, 1, 0, 0, 10, 1, 1); cycle("lw_x10", 0, core::MEM_STAGE, core::RS1, 32'h11);
        id(1, 10, 1, 0, 1, 11, 1, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle("ext_hold", 0, core::MEM_STAGE, core::RS1, 32'h11);
        cmp("hold.count", perf_load_use_o, PERF ? 32'd1 : 32'd0);
        stall_i = 1'b0;
        cycle("ext_lu_stall", 1, core::NONE_STAGE, core::RS_NONE, 32'd0);
        cycle("ext_lu_fwd", 0, core::WB_STAGE, core::RS1, 32'h22);
        cmp("ext.count", perf_load_use_o, PERF ? 32'd2 : 32'd0);

        // flush coincident with a load-use hazard kills the ID instruction
        id(1, 0, 1, 0, 0, 12, 1, 1); cycle("lw_x12", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 12, 1, 0, 1, 13, 1, 0);
        flush_i = 1'b1;
        cycle("flush", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        flush_i = 1'b0;
        id(1, 12, 1, 12, 1, 14, 1, 0); cycle("post_flush", 0, core::WB_STAGE, core::RS_BOTH, 32'h22);
        cmp("flush.count", perf_load_use_o, PERF ? 32'd2 : 32'd0);

        // reset asserted during a load-use stall
        id(1, 0, 1, 0, 0, 15, 1, 1); cycle("lw_x15", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);
        id(1, 15, 1, 0, 1, 16, 1, 0);
        #1;
        cmp("pre_rst.stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        #1;
        cmp("mid_rst.stall", 32'(stall_o), 32'd0);
        cmp("mid_rst.stage", 32'(fw_cntrl_o.stage), 32'(core::NONE_STAGE));
        cmp("mid_rst.bypass", bypass_o.rd, 32'd0);
        cmp("mid_rst.lu", perf_load_use_o, 32'd0);
        cmp("mid_rst.sp", perf_split_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle("post_rst", 0, core::NONE_STAGE, core::RS_NONE, 32'd0);

        cmp("sb.drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
